// File: rtl/ws2812_decoder.sv
`timescale 1ns/1ps
// ws2812_decoder: measures WS2812 high pulses on a synchronised data line,
// classifies them as 0/1 bits, assembles 24-bit GRB pixels MSB-first and
// hands the line over to the downstream reshaper once NUM_PIXELS pixels of
// the current frame have been consumed.
//
// Ports:
//   i_clk            clock
//   i_reset          synchronous, active-high reset
//   i_signal_synced  data line, already synchronised to i_clk
//   o_pixel_data     last assembled pixel, held until the next one
//   o_pixel_valid    one-cycle strobe, o_pixel_data is new
//   o_pixel_index    0-based index of the pixel on o_pixel_data (saturates)
//   o_passthru_en    level, high while downstream should forward the line
//   o_frame_done     one-cycle strobe on latch (reset low period) detection
//   o_bit_error      one-cycle strobe on a malformed pulse or truncated pixel
module ws2812_decoder #(
    parameter int unsigned CNT_WIDTH    = 12,
    parameter int unsigned T_HIGH_MIN   = 8,
    parameter int unsigned T_BIT_THRESH = 30,
    parameter int unsigned T_HIGH_MAX   = 60,
    parameter int unsigned T_LATCH      = 2500,
    parameter int unsigned NUM_PIXELS   = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_signal_synced,
    output logic [23:0] o_pixel_data,
    output logic        o_pixel_valid,
    output logic [7:0]  o_pixel_index,
    output logic        o_passthru_en,
    output logic        o_frame_done,
    output logic        o_bit_error
);

    localparam int unsigned PIX_W    = 24;
    localparam int unsigned BITCNT_W = 5;
    localparam int unsigned IDX_W    = 8;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [IDX_W-1:0]     IDX_MAX = '1;

    typedef enum logic [1:0] {
        WAIT_LATCH = 2'd0,
        DECODE     = 2'd1,
        PASSTHRU   = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  prev_q;
    logic [CNT_WIDTH-1:0]  high_cnt_q, high_cnt_d;
    logic [CNT_WIDTH-1:0]  low_cnt_q, low_cnt_d;
    logic [PIX_W-1:0]      shift_q, shift_d;
    logic [BITCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]      pix_cnt_q, pix_cnt_d;
    logic [PIX_W-1:0]      pixel_data_q, pixel_data_d;
    logic                  pixel_valid_q, pixel_valid_d;
    logic [IDX_W-1:0]      pixel_index_q, pixel_index_d;
    logic                  passthru_q, passthru_d;
    logic                  frame_done_q, frame_done_d;
    logic                  bit_error_q, bit_error_d;

    logic                  rise_c, fall_c;
    logic                  latch_c, overlong_c, width_bad_c, bit_val_c, last_pix_c;
    logic [PIX_W-1:0]      shift_next_c;

    // Edge detection and run-length counters. Each counter includes the
    // current sample, so on a fall high_cnt_q holds the exact high width.
    always_comb begin
        rise_c = ~prev_q & i_signal_synced;
        fall_c = prev_q & ~i_signal_synced;

        high_cnt_d = high_cnt_q;
        if (rise_c) begin
            high_cnt_d = CNT_WIDTH'(1);
        end else if (i_signal_synced && (high_cnt_q != CNT_MAX)) begin
            high_cnt_d = high_cnt_q + CNT_WIDTH'(1);
        end

        low_cnt_d = low_cnt_q;
        if (fall_c) begin
            low_cnt_d = CNT_WIDTH'(1);
        end else if (!i_signal_synced && (low_cnt_q != CNT_MAX)) begin
            low_cnt_d = low_cnt_q + CNT_WIDTH'(1);
        end
    end

    // Event qualifiers. Equality on the counter makes the latch fire once per low run.
    always_comb begin
        latch_c      = ~i_signal_synced & (low_cnt_d == CNT_WIDTH'(T_LATCH));
        overlong_c   = i_signal_synced & (high_cnt_d > CNT_WIDTH'(T_HIGH_MAX));
        width_bad_c  = (high_cnt_q < CNT_WIDTH'(T_HIGH_MIN)) ||
                       (high_cnt_q > CNT_WIDTH'(T_HIGH_MAX));
        bit_val_c    = (high_cnt_q >= CNT_WIDTH'(T_BIT_THRESH));
        shift_next_c = {shift_q[PIX_W-2:0], bit_val_c};
        last_pix_c   = (32'(pix_cnt_q) == 32'(NUM_PIXELS - 1));
    end

    // Frame FSM and registered output next-state.
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        pix_cnt_d     = pix_cnt_q;
        pixel_data_d  = pixel_data_q;
        pixel_index_d = pixel_index_q;
        pixel_valid_d = 1'b0;
        frame_done_d  = 1'b0;
        bit_error_d   = 1'b0;

        case (state_q)
            WAIT_LATCH: begin
                if (latch_c) begin
                    state_d      = DECODE;
                    frame_done_d = 1'b1;
                    shift_d      = '0;
                    bit_cnt_d    = '0;
                    pix_cnt_d    = '0;
                end
            end
            DECODE: begin
                if (latch_c) begin
                    // A partially received pixel at latch time is truncated.
                    frame_done_d = 1'b1;
                    bit_error_d  = (bit_cnt_q != '0);
                    shift_d      = '0;
                    bit_cnt_d    = '0;
                    pix_cnt_d    = '0;
                end else if (overlong_c || (fall_c && width_bad_c)) begin
                    bit_error_d = 1'b1;
                    shift_d     = '0;
                    bit_cnt_d   = '0;
                    state_d     = WAIT_LATCH;
                end else if (fall_c) begin
                    shift_d = shift_next_c;
                    if (bit_cnt_q == BITCNT_W'(PIX_W - 1)) begin
                        pixel_valid_d = 1'b1;
                        pixel_data_d  = shift_next_c;
                        pixel_index_d = pix_cnt_q;
                        bit_cnt_d     = '0;
                        pix_cnt_d     = (pix_cnt_q == IDX_MAX) ? pix_cnt_q
                                                               : pix_cnt_q + IDX_W'(1);
                        if (last_pix_c) begin
                            state_d = PASSTHRU;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BITCNT_W'(1);
                    end
                end
            end
            PASSTHRU: begin
                if (latch_c) begin
                    state_d      = DECODE;
                    frame_done_d = 1'b1;
                    shift_d      = '0;
                    bit_cnt_d    = '0;
                    pix_cnt_d    = '0;
                end
            end
            default: begin
                state_d = WAIT_LATCH;
            end
        endcase

        // Derived from the next state so it moves together with the strobes.
        passthru_d = (state_d == PASSTHRU);
    end

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= WAIT_LATCH;
            prev_q        <= 1'b0;
            high_cnt_q    <= '0;
            low_cnt_q     <= '0;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            pix_cnt_q     <= '0;
            pixel_data_q  <= '0;
            pixel_valid_q <= 1'b0;
            pixel_index_q <= '0;
            passthru_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            bit_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            prev_q        <= i_signal_synced;
            high_cnt_q    <= high_cnt_d;
            low_cnt_q     <= low_cnt_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            pix_cnt_q     <= pix_cnt_d;
            pixel_data_q  <= pixel_data_d;
            pixel_valid_q <= pixel_valid_d;
            pixel_index_q <= pixel_index_d;
            passthru_q    <= passthru_d;
            frame_done_q  <= frame_done_d;
            bit_error_q   <= bit_error_d;
        end
    end

    assign o_pixel_data  = pixel_data_q;
    assign o_pixel_valid = pixel_valid_q;
    assign o_pixel_index = pixel_index_q;
    assign o_passthru_en = passthru_q;
    assign o_frame_done  = frame_done_q;
    assign o_bit_error   = bit_error_q;

endmodule

// File: doc/ws2812_decoder.md
Name: ws2812_decoder

Overview:
- Upstream stage of the WS2812 chain. Samples the synchronised data line and measures each high pulse.
- Classifies each pulse as a 0 or 1 bit and assembles 24-bit pixels MSB-first, in GRB order as received.
- Consumes the first NUM_PIXELS pixels after each latch, then asserts o_passthru_en so the downstream reshaper forwards the rest of the frame.
- Detects latch (reset) low periods and malformed pulses.

Parameters:
- CNT_WIDTH, 12, width of the high-time and low-time counters; both saturate at all-ones.
- T_HIGH_MIN, 8, minimum legal high width in cycles; shorter pulses are errors.
- T_BIT_THRESH, 30, high width >= this is a 1 bit, otherwise a 0 bit.
- T_HIGH_MAX, 60, maximum legal high width in cycles; longer pulses are errors.
- T_LATCH, 2500, low width in cycles that constitutes a latch (50 us at 50 MHz).
- NUM_PIXELS, 1, pixels consumed per frame before passthrough; must be >= 1.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_signal_synced  in  1  data line, already synchronised to i_clk
- o_pixel_data  out  24  last assembled pixel, held until the next pixel is assembled
- o_pixel_valid  out  1  one-cycle strobe; o_pixel_data is new
- o_pixel_index  out  8  index of the pixel on o_pixel_data, 0-based within the frame
- o_passthru_en  out  1  level; high while downstream should forward the line
- o_frame_done  out  1  one-cycle strobe on latch detection
- o_bit_error  out  1  one-cycle strobe on a malformed pulse or truncated pixel

Behaviour:
- Reset:
  - All outputs 0, counters 0, shift register 0, bit count 0, state WAIT_LATCH.
  - A reset asserted mid-frame aborts everything; no strobes fire on the reset cycle.
- Edge detection:
  - r_prev holds the registered i_signal_synced.
  - Rise = !r_prev & i_signal_synced. Fall = r_prev & !i_signal_synced.
- Counters:
  - High counter clears on a rise and increments while the input is high.
  - Low counter clears on a fall and increments while the input is low.
  - Both saturate at all-ones.
- State machine:
  - WAIT_LATCH: ignore pulses. When the low counter reaches T_LATCH, go to DECODE, clear bit and pixel counts, pulse o_frame_done. Starting decode mid-frame is forbidden.
  - DECODE, on each fall, with W = high width:
    - W < T_HIGH_MIN or W > T_HIGH_MAX: pulse o_bit_error, discard the partial pixel, go to WAIT_LATCH.
    - Otherwise shift in (W >= T_BIT_THRESH) at the LSB and increment the bit count.
  - DECODE, while high: if the high counter exceeds T_HIGH_MAX, do not wait for the fall; apply the same error handling immediately.
  - DECODE, on the 24th bit:
    - The cycle after the fall is sampled: o_pixel_data = the 24 shifted bits, o_pixel_valid = 1, o_pixel_index = pixel count.
    - Pixel count increments and bit count clears.
    - If this was pixel NUM_PIXELS-1, go to PASSTHRU and set o_passthru_en in the same cycle as o_pixel_valid.
  - DECODE, latch reached: pulse o_frame_done and stay in DECODE with counts cleared. If bit count != 0, also pulse o_bit_error (truncated pixel) and discard the partial pixel.
  - PASSTHRU:
    - o_passthru_en stays 1 and pulses are not decoded.
    - When the low counter reaches T_LATCH: o_passthru_en drops to 0 that same cycle, o_frame_done pulses, go to DECODE with counts cleared.
- Latch detection: fires exactly once per low period, on the cycle the low counter equals T_LATCH; later low cycles do not re-trigger.
- Latency: the fall is sampled in cycle N; classification and shift happen in N; o_pixel_valid is asserted in N+1.
- Simultaneous events: a fall and the latch condition cannot coincide, since the low counter is 0 on a fall. An error and the last bit cannot coincide, since error takes precedence.
- Pixel index saturates at 255.

Test Plan:
- Reset, low for 2500 cycles, then 24 pulses (high 15 / low 45 for bit 0; high 40 / low 20 for bit 1) encoding 0xA5C30F:
  - o_frame_done pulses once at low cycle 2500.
  - o_pixel_valid pulses once with data 0xA5C30F and index 0.
  - o_passthru_en rises in the same cycle and stays high.
- After the previous case, another 48 bits of traffic, then a 2500-cycle low:
  - No further o_pixel_valid.
  - o_passthru_en falls and o_frame_done pulses in the same cycle.
- Boundary widths after latch: high 8 gives bit 0; 29 gives bit 0; 30 gives bit 1; 60 gives bit 1. High 7 or 61 gives an o_bit_error pulse and a return to WAIT_LATCH; later pulses are ignored until the next latch.
- Stuck-high line of 200 cycles during DECODE: o_bit_error asserted at high cycle 61, o_passthru_en stays 0.
- Pulses without a preceding latch after reset: no o_pixel_valid and no o_passthru_en until 2500 low cycles are seen.
- NUM_PIXELS=2, latch after 10 bits:
  - o_frame_done and o_bit_error pulse together.
  - The following 48 bits yield valid strobes with indices 0 then 1; passthru rises with index 1.
  - Assert i_reset mid-pixel: all outputs return to 0 the next cycle.
